// File: rtl/spi_master.sv
// spi_master: single-slave SPI master, mode 0 (sck idles low, slave samples
// mosi on the rising edge). One request is accepted at a time over a
// valid/ready channel; up to MAX_BITS bits are shifted MSB-first while miso
// is captured. The captured word is returned over a valid/ready channel.
module spi_master #(
    parameter int MAX_BITS = 16,
    parameter int LEN_W    = 5,
    parameter int DIV_W    = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [LEN_W-1:0]    req_len,
    input  logic [MAX_BITS-1:0] req_txd,
    input  logic [DIV_W-1:0]    req_div,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [MAX_BITS-1:0] resp_rxd,
    output logic                sck,
    output logic                ss_n,
    output logic                mosi,
    input  logic                miso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

    state_t                r_state;
    state_t                w_next;
    logic [LEN_W-1:0]      r_len;
    logic [DIV_W-1:0]      r_div;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [LEN_W-1:0]      r_bit_cnt;
    logic [MAX_BITS-1:0]   r_tx;
    logic [MAX_BITS-1:0]   r_rx;

    logic [LEN_W-1:0]      w_len_clamped;
    logic                  w_phase_end;
    logic                  w_last_bit;
    logic                  w_bits_done;

    // Over-long requests are clamped to the width of the shift registers.
    assign w_len_clamped = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    // Every SETUP/HIGH/LOW phase lasts div+1 cycles.
    assign w_phase_end   = (r_div_cnt == r_div);
    // HIGH phase currently running carries the final bit.
    assign w_last_bit    = ((r_bit_cnt + LEN_W'(1)) == r_len);
    // All HIGH phases have completed; the current LOW is the ss hold time.
    assign w_bits_done   = (r_bit_cnt == r_len);
    assign resp_rxd      = r_rx;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and pin/handshake outputs, all derived from state.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        sck        = 1'b0;
        ss_n       = 1'b1;
        mosi       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = (w_len_clamped == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                ss_n = 1'b0;
                mosi = r_tx[MAX_BITS-1];
                if (w_phase_end) w_next = S_HIGH;
            end
            S_HIGH: begin
                ss_n = 1'b0;
                sck  = 1'b1;
                mosi = r_tx[MAX_BITS-1];
                if (w_phase_end) w_next = S_LOW;
            end
            S_LOW: begin
                ss_n = 1'b0;
                mosi = r_tx[MAX_BITS-1];
                if (w_phase_end) w_next = w_bits_done ? S_DONE : S_HIGH;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: request latch, divider/bit counters, tx and rx shift registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_len     <= '0;
            r_div     <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_len     <= w_len_clamped;
                        r_div     <= req_div;
                        // Left-justify so the first bit to send sits at the MSB.
                        r_tx      <= req_txd << (MAX_LEN - w_len_clamped);
                        r_rx      <= '0;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                S_SETUP, S_LOW: begin
                    r_div_cnt <= w_phase_end ? '0 : r_div_cnt + DIV_W'(1);
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_div_cnt <= '0;
                        r_rx      <= {r_rx[MAX_BITS-2:0], miso};
                        r_bit_cnt <= r_bit_cnt + LEN_W'(1);
                        // The last bit stays on mosi through the hold phase.
                        if (!w_last_bit) r_tx <= r_tx << 1;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-slave SPI master that generates sck/ss/mosi and samples miso for SPI peripherals such as the bit-reversal slave.
- Accepts one transfer command at a time over a valid/ready request channel.
- Shifts up to MAX_BITS bits MSB-first while capturing miso bits into a receive shift register.
- Returns the captured word over a valid/ready response channel.
- Sits between the bus-side SPI controller logic and the off-chip/peripheral SPI pins.

Parameters:
MAX_BITS, 16, maximum bits per transfer; width of req_txd and resp_rxd
LEN_W, 5, width of req_len; must satisfy 2^LEN_W > MAX_BITS
DIV_W, 8, width of the clock-divider field req_div

Ports:
clock  input  1  system clock; all logic on posedge
resetn  input  1  asynchronous reset, active-low
req_valid  input  1  transfer request valid
req_ready  output  1  high only in IDLE
req_len  input  LEN_W  number of bits to transfer
req_txd  input  MAX_BITS  transmit data; bit req_len-1 is sent first
req_div  input  DIV_W  sck half-period = req_div+1 clock cycles
resp_valid  output  1  received data valid
resp_ready  input  1  response consumed
resp_rxd  output  MAX_BITS  received bits in [len-1:0], MSB = first sampled; upper bits 0
sck  output  1  SPI clock; idles low
ss_n  output  1  slave select, active-low
mosi  output  1  master out
miso  input  1  master in; treated as synchronous to clock

Behaviour:
- Reset (resetn=0, asynchronous, effective immediately):
  - state=IDLE.
  - sck=0, ss_n=1, mosi=0.
  - resp_valid=0, resp_rxd=0.
  - All counters cleared.
  - A transfer in progress is abandoned with no response.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE:
  - req_ready=1; outputs at idle values.
  - On req_valid&&req_ready, latch len, div and txd.
  - len is clamped: len > MAX_BITS becomes MAX_BITS.
  - len=0: go straight to DONE next cycle with resp_rxd=0; ss_n never asserted.
  - Otherwise go to SETUP.
- SETUP:
  - ss_n=0, sck=0, mosi=txd[len-1].
  - Lasts div+1 cycles, then HIGH.
- HIGH:
  - sck=1 for div+1 cycles; the slave samples mosi on the rising edge.
  - On the last HIGH cycle, miso is shifted into the rx register LSB (rx <= {rx, miso}).
  - Then go to LOW.
- LOW:
  - sck=0 for div+1 cycles.
  - On LOW entry, mosi advances to the next transmit bit.
  - After the final bit, mosi holds its last value.
  - At the end of LOW: if bits remain, go to HIGH; otherwise go to DONE.
  - The final LOW phase is the ss hold time.
- DONE:
  - ss_n=1, sck=0, mosi=0.
  - resp_valid=1 and resp_rxd is stable.
  - Remain until resp_ready=1, then go to IDLE in the next cycle.
  - resp_valid drops on that same edge.
- Timing (from the accept edge):
  - ss_n is low for exactly (2*len+1)*(div+1) cycles.
  - Exactly len sck rising edges occur.
  - sck high and low phases are each div+1 cycles.
  - resp_valid rises in the cycle ss_n returns high.
- Handshake rules:
  - req_ready=0 in every state except IDLE; requests are never queued.
  - req_len, req_txd and req_div are don't-care outside the accept cycle.
  - A new request can be accepted no earlier than the cycle after the response handshake.
- Counters:
  - Divider counter is DIV_W bits; no overflow, since it counts 0..div.
  - Bit counter is LEN_W bits.
  - The rx register is MAX_BITS wide, so upper bits stay 0 for len < MAX_BITS.

Test Plan:
- Reset mid-transfer: assert resetn=0 during a HIGH phase -> sck=0, ss_n=1, mosi=0, resp_valid=0 in the same cycle. After release, req_ready=1 and no response appears.
- Bit-reversal slave loop: len=16, div=0, txd=0x0100 against the bitrev slave -> resp_rxd=0x0080. Also txd=0x0300 -> 0x00C0. Confirm ss_n low exactly 33 cycles and 16 sck rising edges.
- Divider timing: len=4, div=3, txd=0xA, miso tied 1 -> each sck phase is 4 cycles, mosi sequence 1,0,1,0, ss_n low 36 cycles, resp_rxd=0x000F.
- Response backpressure: hold resp_ready=0 for 10 cycles after DONE -> resp_valid stays 1, resp_rxd stable, req_ready=0. Then resp_ready=1 -> IDLE next cycle.
- Boundaries:
  - len=0 -> resp_valid after 1 cycle, rxd=0, ss_n never low.
  - len=31 -> clamped to 16 rising edges.
  - len=1, miso=1 -> resp_rxd=0x0001.
- Back-to-back: keep req_valid=1 continuously with resp_ready=1 -> second accept occurs exactly one cycle after the first response handshake, and ss_n deasserts for at least one cycle between transfers.
